// File: rtl/alu_seq_pkg.sv
// Package for the ALU issue sequencer.
// Holds the request command codes, the sequencer state encoding, the ALU
// operand/result widths and a helper that decides whether a request is
// answered directly with an error instead of driving the ALU.
// Optional feature macro: ALU_WIDE_MUL_EN (enables the two-pass WMUL command).
package alu_seq_pkg;

  localparam int ALU_RES_W = 15;
  localparam int ALU_OP_W  = 16;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_AND  = 3'd2;
  localparam logic [2:0] CMD_MP0  = 3'd3;
  localparam logic [2:0] CMD_MP1  = 3'd4;
  localparam logic [2:0] CMD_DV0  = 3'd5;
  localparam logic [2:0] CMD_DV1  = 3'd6;
  localparam logic [2:0] CMD_WMUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE_LO = 2'd1,
    ST_DRIVE_HI = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  // A request is trapped when it would divide by a zero magnitude, or when it
  // asks for the wide multiply in a build that does not support it.
  function automatic logic is_trap(input logic [2:0] cmd, input logic [ALU_OP_W-1:0] b);
    logic trap;
    trap = ((cmd == CMD_DV0) || (cmd == CMD_DV1)) && (b[ALU_OP_W-1:1] == '0);
`ifndef ALU_WIDE_MUL_EN
    if (cmd == CMD_WMUL) trap = 1'b1;
`endif
    return trap;
  endfunction

endpackage

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue/sequencing stage in front of the ALU.
// Accepts one request at a time, drives A/B/command to the ALU and holds them
// for SETTLE_CYC cycles, samples the result and returns it with the request
// tag. Divide-by-zero (and WMUL when unsupported) is answered with an error
// without touching the ALU outputs.
// Optional feature macro: ALU_WIDE_MUL_EN -- when defined, cmd 7 runs MP0 then
// MP1 and returns the 30-bit product {MP1,MP0}.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake; req_a/req_b/req_cmd/req_tag payload
//   alu_a/alu_b/alu_cmd        operands and command to the ALU (cmd never 7)
//   alu_res                    15-bit result from the ALU
//   rsp_valid/rsp_ready        response handshake; rsp_data/rsp_tag/rsp_err payload
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A raised valid keeps its payload stable and is never withdrawn until
// the transfer; ready may change freely and a valid seen while ready is low is
// simply ignored.
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int TAG_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ALU_OP_W-1:0]    req_a,
  input  logic [ALU_OP_W-1:0]    req_b,
  input  logic [2:0]             req_cmd,
  input  logic [TAG_W-1:0]       req_tag,
  output logic [ALU_OP_W-1:0]    alu_a,
  output logic [ALU_OP_W-1:0]    alu_b,
  output logic [2:0]             alu_cmd,
  input  logic [ALU_RES_W-1:0]   alu_res,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*ALU_RES_W-1:0] rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ALU_OP_W-1:0]    alu_a_q, alu_a_d;
  logic [ALU_OP_W-1:0]    alu_b_q, alu_b_d;
  logic [2:0]             alu_cmd_q, alu_cmd_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [2*ALU_RES_W-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
`ifdef ALU_WIDE_MUL_EN
  logic                   wide_q, wide_d;
  logic [ALU_RES_W-1:0]   lo_q, lo_d;
`endif

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cmd   = alu_cmd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_WIDE_MUL_EN
    wide_d      = wide_q;
    lo_d        = lo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          tag_d = req_tag;
          if (is_trap(req_cmd, req_b)) begin
            // Answered next cycle; ALU outputs keep their previous values.
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            // WMUL starts with the low-half multiply.
            alu_cmd_d = (req_cmd == CMD_WMUL) ? CMD_MP0 : req_cmd;
            cnt_d     = CNT_INIT;
            rsp_err_d = 1'b0;
`ifdef ALU_WIDE_MUL_EN
            wide_d    = (req_cmd == CMD_WMUL);
`endif
            state_d   = ST_DRIVE_LO;
          end
        end
      end
      ST_DRIVE_LO: begin
        if (cnt_q == '0) begin
`ifdef ALU_WIDE_MUL_EN
          if (wide_q) begin
            lo_d      = alu_res;
            alu_cmd_d = CMD_MP1;
            cnt_d     = CNT_INIT;
            state_d   = ST_DRIVE_HI;
          end else begin
            rsp_data_d  = {{ALU_RES_W{1'b0}}, alu_res};
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
`else
          rsp_data_d  = {{ALU_RES_W{1'b0}}, alu_res};
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef ALU_WIDE_MUL_EN
      ST_DRIVE_HI: begin
        if (cnt_q == '0) begin
          rsp_data_d  = {alu_res, lo_q};
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_RESP: begin
        // No new accept in this cycle: req_ready is low in RESP.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_WIDE_MUL_EN
      wide_q      <= 1'b0;
      lo_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_WIDE_MUL_EN
      wide_q      <= wide_d;
      lo_q        <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Testbench for alu_issue_seq. An ALU stand-in answers alu_* combinationally;
// the driver issues requests and pushes expected responses, a negedge monitor
// pops and compares on each response handshake and also checks latency, ALU
// drive sequence, response stability and req_ready behaviour.
module tb_alu_issue_seq;
  import alu_seq_pkg::*;

  localparam int S = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [2:0]  req_cmd;
  logic [3:0]  req_tag;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_cmd;
  logic [14:0] alu_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [29:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  alu_issue_seq #(.SETTLE_CYC(S), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- ALU stand-in ----------------
  function automatic logic [14:0] alu_stub(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] cmd);
    logic [14:0] ma, mb;
    logic [29:0] p;
    ma = a[15:1];
    mb = b[15:1];
    p  = {15'b0, ma} * {15'b0, mb};
    case (cmd)
      3'd0: return ma + mb;
      3'd1: return ma - mb;
      3'd2: return ma & mb;
      3'd3: return p[14:0];
      3'd4: return p[29:15];
      3'd5: return (mb == 15'd0) ? 15'h7fff : ma / mb;
      3'd6: return (mb == 15'd0) ? 15'd0 : ma % mb;
      default: return 15'd0;
    endcase
  endfunction

  assign alu_res = alu_stub(alu_a, alu_b, alu_cmd);

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                    input logic [2:0] cmd, output logic [29:0] data,
                                    output logic trap, output logic wide);
    longint ma, mb, r;
    ma = longint'(a >> 1);
    mb = longint'(b >> 1);
    r = 0; trap = 1'b0; wide = 1'b0;
    case (cmd)
      3'd0: r = (ma + mb) % 32768;
      3'd1: r = (ma - mb + 32768) % 32768;
      3'd2: r = ma & mb;
      3'd3: r = (ma * mb) % 32768;
      3'd4: r = (ma * mb) / 32768;
      3'd5: if (mb == 0) trap = 1'b1; else r = ma / mb;
      3'd6: if (mb == 0) trap = 1'b1; else r = ma % mb;
      default: begin
`ifdef ALU_WIDE_MUL_EN
        r = ma * mb; wide = 1'b1;
`else
        trap = 1'b1;
`endif
      end
    endcase
    if (trap) r = 0;
    data = 30'(r);
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];   // {err, tag, data}
  logic [40:0] info_q[$];  // {lat[3:0], wide, trap, cmd0[2:0], a, b}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic        busy = 1'b0;
  logic        seen = 1'b0;
  logic        prev_hs = 1'b0;
  logic [2:0]  last_cmd = 3'd0;
  int          acc_cyc = 0;
  logic [3:0]  act_lat;
  logic        act_wide, act_trap;
  logic [2:0]  act_cmd0;
  logic [15:0] act_a, act_b;
  logic [34:0] held;

  always @(negedge clk) begin
    logic hs;
    logic [34:0] e;
    logic [40:0] inf;
    int k;
    hs = 1'b0;
    if (reset) begin
      busy = 1'b0; seen = 1'b0; prev_hs = 1'b0; last_cmd = 3'd0;
    end else begin
      if (busy && !act_trap && !rsp_valid) begin
        k = cyc - acc_cyc;
        chk("alu_cmd_drive", 64'(alu_cmd), 64'((k <= S) ? act_cmd0 : CMD_MP1));
        chk("alu_a_drive", 64'(alu_a), 64'(act_a));
        chk("alu_b_drive", 64'(alu_b), 64'(act_b));
      end
      if (rsp_valid) begin
        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (!busy) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=valid expected=idle cycle=%0d", cyc);
        end else if (!seen) begin
          chk("rsp_latency", 64'(cyc - acc_cyc - 1), 64'(act_lat));
          if (act_trap) chk("alu_cmd_trap_hold", 64'(alu_cmd), 64'(last_cmd));
          seen = 1'b1;
        end else begin
          chk("rsp_stable", 64'({rsp_err, rsp_tag, rsp_data}), 64'(held));
        end
        held = {rsp_err, rsp_tag, rsp_data};
        if (rsp_ready) begin
          hs = 1'b1; seen = 1'b0; busy = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_no_expected actual=data_%0h expected=none", rsp_data);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", 64'(rsp_data), 64'(e[29:0]));
            chk("rsp_tag", 64'(rsp_tag), 64'(e[33:30]));
            chk("rsp_err", 64'(rsp_err), 64'(e[34]));
          end
        end
      end
      if (prev_hs) chk("req_ready_after_hs", 64'(req_ready), 64'd1);
      prev_hs = hs;
      if (req_valid && req_ready) begin
        if (info_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL accept_no_info actual=accept expected=none");
        end else begin
          inf = info_q.pop_front();
          {act_lat, act_wide, act_trap, act_cmd0, act_a, act_b} = inf;
          acc_cyc = cyc;
          busy = 1'b1;
          if (!act_trap) last_cmd = act_wide ? CMD_MP1 : act_cmd0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_rdy = 1'b0;

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] cmd,
                       input logic [3:0] tag);
    logic [29:0] d;
    logic trap, wide;
    logic [3:0] lat;
    int n;
    ref_model(a, b, cmd, d, trap, wide);
    lat = trap ? 4'd0 : (wide ? 4'(2 * S) : 4'(S));
    exp_q.push_back({trap, tag, d});
    info_q.push_back({lat, wide, trap, (cmd == CMD_WMUL) ? CMD_MP0 : cmd, a, b});
    req_a = a; req_b = b; req_cmd = cmd; req_tag = tag; req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=no_accept expected=accept tag=%0d", tag);
        void'(exp_q.pop_back());
        void'(info_q.pop_back());
        break;
      end
      if (rand_rdy) begin
        @(posedge clk); #1;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    req_cmd = 3'($urandom_range(0, 7)); req_tag = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 500);
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=pending_%0d expected=0", exp_q.size());
    end
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_cmd"}, 64'(alu_cmd), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cmd = '0; req_tag = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("por_req_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // ADD, then a divide trap, then WMUL and a second trap after it
    issue(16'h0006, 16'h0004, CMD_ADD, 4'd3);
    wait_drain();
    issue(16'h1234, 16'h0001, CMD_DV1, 4'd5);
    wait_drain();
    issue(16'h7FFE, 16'h7FFE, CMD_WMUL, 4'd6);
    wait_drain();
    issue(16'h0100, 16'h0000, CMD_DV0, 4'd7);
    wait_drain();

    // backpressure: hold the response for 5 cycles, then drain and re-issue
    rsp_ready = 1'b0;
    issue(16'h0020, 16'h0010, CMD_SUB, 4'd8);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL bp_rsp_timeout actual=no_valid expected=valid");
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(16'h00F0, 16'h0F0F, CMD_AND, 4'd9);
    wait_drain();

    // reset while a SUB is in DRIVE_LO
    issue(16'h0100, 16'h0020, CMD_SUB, 4'd10);
    reset = 1'b1;
    exp_q.delete();
    info_q.delete();
    @(posedge clk); #1;
    chk_reset_outputs("midop");
    reset = 1'b0;
    @(negedge clk);
    chk("midop_req_ready_after", 64'(req_ready), 64'd1);
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;

    // back-to-back random narrow ops, tags 0..9
    for (int i = 0; i < 10; i++)
      issue(16'($urandom), 16'($urandom), 3'($urandom_range(0, 6)), 4'(i));
    wait_drain();

    // random ops including WMUL with random response backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] b;
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b[15:1] = '0;
      issue(16'($urandom), b, 3'($urandom_range(0, 7)), 4'(i));
    end
    rand_rdy = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
